z_cla_pipe_adder: RTL

Z_CLA_PIPE_ADDER -- requirements
Module: z_cla_pipe_adder

---
 rtl/z_cla_pipe_adder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/z_cla_pipe_adder.sv
// z_cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
//
// The operand word is split into WIDTH/GROUP lookahead groups. Each pipeline
// stage resolves a fixed slice of groups: it turns that slice's pending g/p
// bits into sum bits using the carry left by the previous stage, then hands
// the next boundary carry on. The last stage's register drives the outputs.
// Every stage holds while the output is valid and not accepted, so in_ready
// is the pipeline advance enable.
//
// Optional feature: define Z_CLA_OVF_EN to compute and pipeline the signed
// overflow flag. Without it, overflow is tied to 0 and the carry into the MSB
// is not stored anywhere.
module z_cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NGROUPS = WIDTH / GROUP;
  // Groups resolved per stage; a trailing stage may get fewer groups, or none.
  localparam int GPS     = (NGROUPS + STAGES - 1) / STAGES;

  // One pipeline slot. Sum bits of unresolved groups are still zero, and the
  // g/p bits of resolved groups are no longer needed.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             c;      // carry into the first unresolved group; carry out of the MSB at the end
`ifdef Z_CLA_OVF_EN
    logic             c_msb;  // carry into bit WIDTH-1, captured when the top group is resolved
`endif
  } stage_t;

  logic [WIDTH-1:0] w_b_eff;
  stage_t           w_head;
  stage_t           w_next  [STAGES];
  stage_t           r_stage [STAGES];
  logic             w_advance;

  // The whole pipeline moves together. A bubble in the output slot never
  // blocks it, and a stalled result holds every stage behind it.
  assign w_advance = !r_stage[STAGES-1].valid || out_ready;
  assign in_ready  = w_advance;

  // Form the effective operand and the per-bit generate/propagate vectors.
  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path can leave it holding its old value (an inferred latch).
  always_comb begin
    w_b_eff      = sub ? ~b : b;
    w_head       = '0;
    w_head.valid = in_valid;
    w_head.g     = a & w_b_eff;
    w_head.p     = a ^ w_b_eff;
    w_head.c     = c_in ^ sub;
  end

  // Resolve each stage's slice of groups using the boundary carry it is given.
  always_comb begin
    stage_t v_in;
    logic   v_carry;
    logic   v_bit_c;
    logic   v_gg;
    logic   v_gp;
    v_in    = '0;
    v_carry = 1'b0;
    v_bit_c = 1'b0;
    v_gg    = 1'b0;
    v_gp    = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      v_in      = (k == 0) ? w_head : r_stage[(k == 0) ? 0 : k - 1];
      w_next[k] = v_in;
      v_carry   = v_in.c;
      for (int j = k * GPS; j < (k + 1) * GPS && j < NGROUPS; j++) begin
        // Bit carries inside the group produce the sum bits; the group's own
        // G/P give the carry out as G | (P & carry in).
        v_bit_c = v_carry;
        v_gg    = 1'b0;
        v_gp    = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
          w_next[k].s[j*GROUP+i] = v_in.p[j*GROUP+i] ^ v_bit_c;
`ifdef Z_CLA_OVF_EN
          if (j * GROUP + i == WIDTH - 1) begin
            w_next[k].c_msb = v_bit_c;
          end
`endif
          v_bit_c = v_in.g[j*GROUP+i] | (v_in.p[j*GROUP+i] & v_bit_c);
          v_gg    = v_in.g[j*GROUP+i] | (v_in.p[j*GROUP+i] & v_gg);
          v_gp    = v_gp & v_in.p[j*GROUP+i];
        end
        v_carry = v_gg | (v_gp & v_carry);
      end
      w_next[k].c = v_carry;
    end
  end

  // Pipeline registers: advance all stages together or hold them all.
  // NOTE: the data fields are reset too, not only the valid bits, because
  // sum/c_out/overflow come straight from the last stage and must read 0
  // during reset.
  // NOTE: sequential state uses non-blocking assignments so that every stage
  // samples its neighbour's value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= w_next[k];
      end
    end
  end

  assign out_valid = r_stage[STAGES-1].valid;
  assign sum       = r_stage[STAGES-1].s;
  assign c_out     = r_stage[STAGES-1].c;

`ifdef Z_CLA_OVF_EN
  assign overflow  = r_stage[STAGES-1].c_msb ^ r_stage[STAGES-1].c;
`else
  assign overflow  = 1'b0;
`endif

endmodule
